// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master transfer engine.
//   state_e     : FSM encoding (IDLE/SETUP/SHIFT/HOLD/DONE)
//   MODE0..3    : SPI mode constants, packed as {cpol, cpha}
//   rsp_latency : cycles from the accepting edge until rsp_valid is seen,
//                 for a transfer of n bits with half-period divider d
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // SETUP + 2N shift half periods + HOLD, each D+1 cycles long,
  // plus the cycle in which the command is accepted.
  function automatic int rsp_latency(input int n, input int d);
    return 1 + (2 * n + 2) * (d + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run the half-period counter (SETUP/SHIFT/HOLD)
//   edge_en    : ticks are sclk edges (SHIFT only)
//   clr        : restart counters and load sclk with cpol (command accept)
//   cpol       : idle level loaded on clr
//   div        : half period in cycles minus 1
//   len        : transfer bits minus 1 (selects the last edge)
//   tick       : half period elapsed
//   lead/trail : this tick is a leading / trailing sclk edge
//   last_edge  : this tick is edge 2N
//   sclk       : SPI clock
module spi_sclk_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int LEN_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 edge_en,
  input  logic                 clr,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [LEN_W-1:0]     len,
  output logic                 tick,
  output logic                 lead,
  output logic                 trail,
  output logic                 last_edge,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  // 0-based edge index; 2N-1 = {len, 1'b1} always fits in LEN_W+1 bits.
  logic [LEN_W:0]       edge_q, edge_d;
  logic                 sclk_q, sclk_d;
  logic                 edge_tick;

  // Equality compare only: the counter wraps to 0 on the tick, so an
  // all-ones divider never overflows and a zero divider ticks every cycle.
  assign tick      = en && (cnt_q == div);
  assign edge_tick = tick && edge_en;
  assign lead      = edge_tick && !edge_q[0];
  assign trail     = edge_tick && edge_q[0];
  assign last_edge = edge_tick && (edge_q == {len, 1'b1});
  assign sclk      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      edge_d = '0;
      sclk_d = cpol;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      if (edge_tick) begin
        edge_d = edge_q + (LEN_W + 1)'(1);
        sclk_d = ~sclk_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master transfer engine: configurable length, mode, divider and CS.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   cmd_*      : command channel; cmd_data right-justified TX word,
//                cmd_len = bits-1, cmd_cs = chip-select index
//   cpol, cpha, clk_div : transfer configuration, captured at accept
//   rsp_*      : response channel; rsp_data right-justified, zero-extended
//   busy       : engine not idle
//   sclk, mosi, miso, cs_n : SPI pins
//   dbg_state  : current FSM state
// Handshake: a beat transfers on a cycle where valid && ready. cmd_ready is
// high only in IDLE; rsp_valid is high only in DONE and holds rsp_data
// stable until rsp_ready. Leaving DONE takes one cycle, so a command offered
// together with rsp_ready is accepted on the following cycle.
module spi_master_core
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int LEN_W      = $clog2(DATA_WIDTH),
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [CS_W-1:0]       cmd_cs,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_CS-1:0]     cs_n,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  mosi_q, mosi_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CS_W-1:0]       cs_q, cs_d;
  logic                  cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;

  logic                  accept, active;
  logic                  tick, lead, trail, last_edge;
  logic [LEN_W-1:0]      tx_shamt;
  logic [DATA_WIDTH-1:0] tx_align;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign active    = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     (state_q == ST_HOLD);
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rsp_data_q;
  assign mosi      = mosi_q;
  assign dbg_state = state_q;

  // Left-align the TX word so bit N-1 sits at the MSB; bits above N-1 fall
  // off the top and are never sent.
  assign tx_shamt = LEN_W'(DATA_WIDTH - 1) - cmd_len;
  assign tx_align = cmd_data << tx_shamt;

  // sclk is loaded from the live cpol pin at accept, so it needs no copy here.
  spi_sclk_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .LEN_W     (LEN_W)
  ) u_sclk_gen (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .en        (active),
    .edge_en   (state_q == ST_SHIFT),
    .clr       (accept),
    .cpol      (cpol),
    .div       (div_q),
    .len       (len_q),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge),
    .sclk      (sclk)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    mosi_d     = mosi_q;
    len_d      = len_q;
    cs_d       = cs_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_SETUP;
          tx_d    = tx_align;
          rx_d    = '0;
          len_d   = cmd_len;
          cs_d    = cmd_cs;
          cpha_d  = cpha;
          div_d   = clk_div;
          // cpha=0 presents the first bit before the first leading edge.
          if (!cpha) mosi_d = tx_align[DATA_WIDTH-1];
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (lead) begin
          if (cpha_q) begin
            mosi_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end else begin
            rx_d = {rx_q[DATA_WIDTH-2:0], miso};
          end
        end
        if (trail) begin
          if (cpha_q) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], miso};
          end else if (!last_edge) begin
            mosi_d = tx_q[DATA_WIDTH-2];
            tx_d   = tx_q << 1;
          end
        end
        if (last_edge) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) begin
          state_d    = ST_DONE;
          rsp_data_d = rx_q;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An out-of-range index matches no line, so every cs_n stays high.
  always_comb begin
    cs_n = '1;
    if (active) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (32'(cs_q) == i) cs_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      mosi_q     <= 1'b0;
      len_q      <= '0;
      cs_q       <= '0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
      mosi_q     <= mosi_d;
      len_q      <= len_d;
      cs_q       <= cs_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core. A second instance with NUM_CS=6 (3-bit cmd_cs)
// shares every input so an out-of-range chip select (7) can be exercised.
module tb_spi_master_core;
  import spi_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data  = '0;
  logic [3:0]  cmd_len   = '0;
  logic [2:0]  cmd_cs    = '0;
  logic        cpol      = 1'b0;
  logic        cpha      = 1'b0;
  logic [15:0] clk_div   = '0;
  logic        rsp_ready = 1'b0;
  logic        loop_en   = 1'b0;
  logic        miso_drv  = 1'b0;
  logic        miso;

  // main instance outputs
  logic        cmd_ready, rsp_valid, busy, sclk, mosi;
  logic [15:0] rsp_data;
  logic [3:0]  cs_n;
  state_e      dbg_state;
  // NUM_CS=6 instance outputs
  logic        cmd_ready6, rsp_valid6, busy6, sclk6, mosi6;
  logic [15:0] rsp_data6;
  logic [5:0]  cs_n6;
  state_e      dbg_state6;

  assign miso = loop_en ? mosi : miso_drv;

  spi_master_core #(.DATA_WIDTH(16), .NUM_CS(4), .DIV_WIDTH(16)) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .cmd_cs(cmd_cs[1:0]), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n), .dbg_state(dbg_state)
  );

  spi_master_core #(.DATA_WIDTH(16), .NUM_CS(6), .DIV_WIDTH(16)) u_dut_cs (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready6), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .cmd_cs(cmd_cs), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data6), .busy(busy6), .sclk(sclk6), .mosi(mosi6),
    .miso(miso), .cs_n(cs_n6), .dbg_state(dbg_state6)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic last_cpol = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;      // {cpol, cpha}
    logic [3:0]  len;
    logic [2:0]  cs;
    logic [15:0] div;
    logic [15:0] data;
    logic        loop;      // miso tied to mosi
    logic [15:0] pat;       // slave reply, MSB (bit len) first
    logic [15:0] exp_rsp;
    logic [15:0] exp_mosi;  // bits seen by the slave on its sampling edges
    int          exp_lat;
    int          exp_edges;
    logic [3:0]  exp_cs_n;  // pattern while selected (4'hF = never)
    logic [5:0]  exp_cs6;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] mode, input logic [3:0] len, input logic [2:0] cs,
                       input logic [15:0] div, input logic [15:0] data);
    @(negedge clk);
    cpol = mode[1]; cpha = mode[0]; cmd_len = len; cmd_cs = cs;
    clk_div = div; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    check("issue_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    last_cpol = mode[1];
  endtask

  // Counts cycles after the accepting edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic ack_rsp(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({nm, "_rsp_valid_after_ack"}, 32'(rsp_valid), 32'd0);
    check({nm, "_cmd_ready_after_ack"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   lat, edges, cs_low, cs_bad, cs6_low, cs6_bad, n, idx, exp_low, exp_low6;
    logic prev, cpol_v, cpha_v;
    logic [15:0] mosi_w;
    cpol_v = v.mode[1];
    cpha_v = v.mode[0];
    n = int'(v.len) + 1;
    lat = 0; edges = 0; cs_low = 0; cs_bad = 0; cs6_low = 0; cs6_bad = 0;
    mosi_w = '0;
    loop_en  = v.loop;
    miso_drv = cpha_v ? 1'b0 : v.pat[v.len];
    @(negedge clk);
    check({nm, "_sclk_idle_before"}, 32'(sclk), 32'(last_cpol));
    issue(v.mode, v.len, v.cs, v.div, v.data);
    prev = cpol_v;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (cs_n != 4'hF) begin
        cs_low++;
        if (cs_n != v.exp_cs_n) cs_bad++;
      end
      if (cs_n6 != 6'h3F) begin
        cs6_low++;
        if (cs_n6 != v.exp_cs6) cs6_bad++;
      end
      if (sclk != prev) begin
        edges++;
        prev = sclk;
        if (edges % 2 == 1) begin
          if (cpha_v) begin
            idx = int'(v.len) - (edges - 1) / 2;
            if (idx >= 0) miso_drv = v.pat[idx];
          end else begin
            mosi_w = {mosi_w[14:0], mosi};
          end
        end else begin
          if (cpha_v) begin
            mosi_w = {mosi_w[14:0], mosi};
          end else if (edges < 2 * n) begin
            idx = int'(v.len) - edges / 2;
            if (idx >= 0) miso_drv = v.pat[idx];
          end
        end
      end
    end
    exp_low  = (v.exp_cs_n == 4'hF) ? 0 : v.exp_lat - 1;
    exp_low6 = (v.exp_cs6 == 6'h3F) ? 0 : v.exp_lat - 1;
    check({nm, "_latency"},     32'(lat),      32'(v.exp_lat));
    check({nm, "_sclk_edges"},  32'(edges),    32'(v.exp_edges));
    check({nm, "_rsp_data"},    32'(rsp_data), 32'(v.exp_rsp));
    check({nm, "_mosi_word"},   32'(mosi_w),   32'(v.exp_mosi));
    check({nm, "_cs_low_cyc"},  32'(cs_low),   32'(exp_low));
    check({nm, "_cs_pattern"},  32'(cs_bad),   32'd0);
    check({nm, "_cs6_low_cyc"}, 32'(cs6_low),  32'(exp_low6));
    check({nm, "_cs6_pattern"}, 32'(cs6_bad),  32'd0);
    check({nm, "_cs_n_done"},   32'(cs_n),     32'h0000000F);
    check({nm, "_sclk_rest"},   32'(sclk),     32'(cpol_v));
    check({nm, "_mosi_hold"},   32'(mosi),     32'(v.data[0]));
    check({nm, "_state_done"},  32'(dbg_state), 32'(ST_DONE));
    check({nm, "_cmd_ready"},   32'(cmd_ready), 32'd0);
    check({nm, "_rsp6_valid"},  32'(rsp_valid6), 32'd1);
    check({nm, "_rsp6_data"},   32'(rsp_data6), 32'(v.exp_rsp));
    check({nm, "_busy6"},       32'(busy6),     32'd1);
    check({nm, "_sclk6"},       32'(sclk6),     32'(cpol_v));
    check({nm, "_mosi6"},       32'(mosi6),     32'(v.data[0]));
    ack_rsp(nm);
    check({nm, "_cmd_ready6"},  32'(cmd_ready6), 32'd1);
    check({nm, "_state6_idle"}, 32'(dbg_state6), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int lat;
    vec_t v;
    //         mode  len  cs   div     data     loop pat      rsp      mosi     lat edg cs_n   cs6
    vecs[0] = '{2'b00, 4'd15, 3'd0, 16'd1, 16'hA5C3, 1'b1, 16'h0000, 16'hA5C3, 16'hA5C3, 69, 32, 4'hE, 6'h3E};
    vecs[1] = '{2'b01, 4'd0,  3'd1, 16'd3, 16'h0001, 1'b0, 16'h0001, 16'h0001, 16'h0001, 17,  2, 4'hD, 6'h3D};
    vecs[2] = '{2'b10, 4'd0,  3'd3, 16'd3, 16'h0001, 1'b0, 16'h0001, 16'h0001, 16'h0001, 17,  2, 4'h7, 6'h37};
    vecs[3] = '{2'b11, 4'd7,  3'd2, 16'd0, 16'h003C, 1'b0, 16'h0096, 16'h0096, 16'h003C, 19, 16, 4'hB, 6'h3B};
    vecs[4] = '{2'b00, 4'd3,  3'd7, 16'd2, 16'h000A, 1'b1, 16'h0000, 16'h000A, 16'h000A, 31,  8, 4'h7, 6'h3F};
    vecs[5] = '{2'b01, 4'd3,  3'd0, 16'd0, 16'hFFF5, 1'b1, 16'h0000, 16'h0005, 16'h0005, 11,  8, 4'hE, 6'h3E};

    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #20;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sclk",      32'(sclk),      32'd0);
    check("rst_mosi",      32'(mosi),      32'd0);
    check("rst_cs_n",      32'(cs_n),      32'h0000000F);
    check("rst_cs_n6",     32'(cs_n6),     32'h0000003F);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response held for 10 cycles while the next command waits.
    loop_en = 1'b1;
    issue(MODE2, 4'd7, 3'd0, 16'd1, 16'h005A);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'(rsp_latency(8, 1)));
    cpol = 1'b0; cpha = 1'b0; cmd_len = 4'd3; cmd_cs = 3'd1;
    clk_div = 16'd0; cmd_data = 16'h0009; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data",  32'(rsp_data),  32'h5A);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_after_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_ack_busy",      32'(busy),      32'd0);
    check("bp_after_ack_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    last_cpol = 1'b0;
    @(negedge clk);
    check("bp_next_busy", 32'(busy), 32'd1);
    check("bp_next_cs_n", 32'(cs_n), 32'h0000000D);
    // One negedge of the new transfer already consumed above.
    wait_rsp(lat);
    check("bp_next_latency", 32'(lat + 1), 32'(rsp_latency(4, 0)));
    check("bp_next_rsp_data", 32'(rsp_data), 32'h9);
    ack_rsp("bp_next");

    // Asynchronous reset in the middle of SHIFT.
    issue(MODE0, 4'd15, 3'd0, 16'd3, 16'hBEEF);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n",      32'(cs_n),      32'h0000000F);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_sclk",      32'(sclk),      32'd0);
    last_cpol = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v = '{2'b00, 4'd15, 3'd1, 16'd0, 16'h1234, 1'b1, 16'h0000, 16'h1234, 16'h1234, 35, 32, 4'hD, 6'h3D};
    run_vec(v, "post_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
